// File: rtl/multisim_client_arbiter_if.sv
// rtl/multisim_client_arbiter_if.sv - requester and downstream handshake bundle for the client arbiter
interface multisim_client_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
) ();
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          out_vld;
    logic                          out_rdy;
    logic [ID_WIDTH+DATA_WIDTH-1:0] out_data;

    // master: the arbiter; slave: the requesters plus the downstream client
    modport master (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data
    );

    modport slave (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data
    );
endinterface

// File: rtl/multisim_client_arbiter.sv
// rtl/multisim_client_arbiter.sv - round-robin N:1 arbiter feeding a single registered output slot
module multisim_client_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multisim_client_arbiter_if.master bus,
    output logic [31:0]               xfer_count
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $fatal(1, "NUM_REQ must be in 2..16");
        end
        if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id_width
            $fatal(1, "ID_WIDTH too small for NUM_REQ");
        end
    endgenerate

    logic [ID_WIDTH-1:0]            ptr;
    logic [ID_WIDTH-1:0]            grant_idx;
    logic [ID_WIDTH-1:0]            ptr_next;
    logic                           grant_found;
    logic [DATA_WIDTH-1:0]          grant_data;
    logic [2*NUM_REQ-1:0]           vld_rot;
    logic [ID_WIDTH:0]              idx_sum;
    logic [NUM_REQ-1:0]             rdy;
    logic                           slot_free;
    logic                           up_xfer;
    logic                           dn_xfer;
    logic                           out_vld_q;
    logic [ID_WIDTH+DATA_WIDTH-1:0] out_data_q;
    logic [31:0]                    cnt_q;

    assign slot_free = !out_vld_q || bus.out_rdy;
    assign dn_xfer   = out_vld_q && bus.out_rdy;
    assign up_xfer   = grant_found && slot_free;

    // Rotating the doubled request vector puts index ptr at bit 0, so the
    // first set bit is the winner's distance from the pointer.
    always_comb begin
        vld_rot     = {bus.req_vld, bus.req_vld} >> ptr;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && vld_rot[k]) begin
                grant_found = 1'b1;
                idx_sum     = {1'b0, ptr} + (ID_WIDTH+1)'(k);
                if (idx_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                    idx_sum = idx_sum - (ID_WIDTH+1)'(NUM_REQ);
                end
                grant_idx = idx_sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        rdy        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                grant_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                rdy[i]     = up_xfer;
            end
        end
    end

    assign ptr_next = ({1'b0, grant_idx} == (ID_WIDTH+1)'(NUM_REQ - 1)) ? '0
                                                                          : grant_idx + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            ptr        <= '0;
        end else if (up_xfer) begin
            out_vld_q  <= 1'b1;
            out_data_q <= {grant_idx, grant_data};
            ptr        <= ptr_next;
        end else if (dn_xfer) begin
            out_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (dn_xfer) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.req_rdy  = rdy;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign xfer_count   = cnt_q;

endmodule
